// File: rtl/pio_pwm_drive.sv
// pio_pwm_drive
//   Turns the 8-bit PIO drive byte into a slew-limited PWM and direction pair
//   for the tiller motor bridge. The byte is signed-magnitude: bit 7 is the
//   direction and bits [6:0] are the magnitude (0..127). The applied magnitude
//   moves by one LSB per ramp interval and always passes through zero before
//   the direction flips, so the bridge never sees an abrupt reversal.
//
// Ports
//   clk          system clock (shared with the PIO)
//   reset_n      asynchronous active-low reset
//   enable       drive enable; low forces the output off and clears the duty
//   cmd[7:0]     drive command from the PIO out_port, [7]=dir, [6:0]=magnitude
//   pwm_out      registered PWM to the bridge
//   dir_out      registered direction to the bridge
//   duty_cur     magnitude currently applied
//   at_target    applied direction and magnitude equal the latched target
//   period_start one-clk pulse at each PWM period boundary
module pio_pwm_drive #(
  parameter int PRESCALE     = 50,
  parameter int RAMP_PERIODS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] cmd,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [6:0] duty_cur,
  output logic       at_target,
  output logic       period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_PERIODS - 1);
  localparam logic [6:0]    PHASE_LAST = 7'd126;

  logic [7:0]    cmd_q_r;
  logic [PW-1:0] presc_r;
  logic [6:0]    phase_r;
  logic [RW-1:0] ramp_r;
  logic          tgt_dir_r;
  logic [6:0]    tgt_mag_r;
  logic [6:0]    duty_r;
  logic          dir_r;
  logic          pwm_r;
  logic          ps_r;

  logic          tick_s;
  logic          wrap_s;
  logic          step_s;
  logic [7:0]    step_nxt_s;

  // One ramp step toward the target, returned as {dir, magnitude}. A pending
  // reversal first walks the magnitude down to zero, then spends one step
  // flipping the direction with the magnitude still at zero.
  function automatic logic [7:0] ramp_step(input logic       cur_dir,
                                           input logic [6:0] cur_mag,
                                           input logic       t_dir,
                                           input logic [6:0] t_mag);
    logic [7:0] res;
    if (cur_dir != t_dir) begin
      if (cur_mag != 7'd0) begin
        res = {cur_dir, cur_mag - 7'd1};
      end else begin
        res = {t_dir, cur_mag};
      end
    end else if (cur_mag < t_mag) begin
      res = {cur_dir, cur_mag + 7'd1};
    end else if (cur_mag > t_mag) begin
      res = {cur_dir, cur_mag - 7'd1};
    end else begin
      res = {cur_dir, cur_mag};
    end
    return res;
  endfunction

  // Timing strobes and the candidate ramp step. The step is evaluated against
  // cmd_q_r because that is the target being latched in the same cycle.
  always_comb begin
    tick_s     = 1'b0;
    wrap_s     = 1'b0;
    step_s     = 1'b0;
    step_nxt_s = {dir_r, duty_r};
    if (enable) begin
      tick_s = (presc_r == PRESC_LAST);
      wrap_s = tick_s && (phase_r == PHASE_LAST);
      step_s = wrap_s && (ramp_r == RAMP_LAST);
    end else begin
      tick_s = 1'b0;
      wrap_s = 1'b0;
      step_s = 1'b0;
    end
    step_nxt_s = ramp_step(dir_r, duty_r, cmd_q_r[7], cmd_q_r[6:0]);
  end

  // Command capture; the PIO runs on clk so a single register suffices.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q_r <= 8'd0;
    end else begin
      cmd_q_r <= cmd;
    end
  end

  // Prescaler, phase and ramp counters; all parked at zero while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= '0;
      phase_r <= 7'd0;
      ramp_r  <= '0;
    end else if (!enable) begin
      presc_r <= '0;
      phase_r <= 7'd0;
      ramp_r  <= '0;
    end else begin
      presc_r <= tick_s ? '0 : presc_r + PW'(1);
      if (tick_s) begin
        phase_r <= (phase_r == PHASE_LAST) ? 7'd0 : phase_r + 7'd1;
      end
      if (wrap_s) begin
        ramp_r <= (ramp_r == RAMP_LAST) ? '0 : ramp_r + RW'(1);
      end
    end
  end

  // Target latch; frozen between boundaries and while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_dir_r <= 1'b0;
      tgt_mag_r <= 7'd0;
    end else if (wrap_s) begin
      tgt_dir_r <= cmd_q_r[7];
      tgt_mag_r <= cmd_q_r[6:0];
    end
  end

  // Applied direction and magnitude. Disable clears the magnitude but keeps
  // the direction so a later re-enable still ramps through zero correctly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_r <= 7'd0;
      dir_r  <= 1'b0;
    end else if (!enable) begin
      duty_r <= 7'd0;
    end else if (step_s) begin
      dir_r  <= step_nxt_s[7];
      duty_r <= step_nxt_s[6:0];
    end
  end

  // PWM comparator and period pulse. Phase tops out at 126, so duty 127 is
  // continuously high and duty 0 continuously low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_r <= 1'b0;
      ps_r  <= 1'b0;
    end else begin
      pwm_r <= enable && (phase_r < duty_r);
      ps_r  <= wrap_s;
    end
  end

  assign pwm_out      = pwm_r;
  assign dir_out      = dir_r;
  assign duty_cur     = duty_r;
  assign period_start = ps_r;
  assign at_target    = (dir_r == tgt_dir_r) && (duty_r == tgt_mag_r);

endmodule

// File: doc/pio_pwm_drive.md
Name: pio_pwm_drive

Overview:
- Downstream consumer of the 8-bit PIO output port that software writes over Avalon.
- Interprets the PIO byte as a signed-magnitude drive command: bit7 is direction, bits[6:0] are magnitude 0..127.
- Generates a slew-limited PWM and direction pair for the actuator (tiller motor bridge) driver.
- Prevents abrupt reversals: magnitude always ramps through zero before direction changes.

Parameters:
- PRESCALE, 50: clk cycles per PWM tick; must be >= 1.
- RAMP_PERIODS, 1: PWM periods per 1-LSB duty step; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  drive enable; low forces output off.
- cmd  input  8  drive command from PIO out_port: [7]=dir, [6:0]=magnitude.
- pwm_out  output  1  registered PWM to bridge.
- dir_out  output  1  registered direction to bridge.
- duty_cur  output  7  current applied magnitude.
- at_target  output  1  high when applied dir and magnitude equal the latched target.
- period_start  output  1  one-clk pulse at each PWM period boundary.

Behaviour:
- Reset (async, reset_n=0): every counter, target register, duty_cur, dir_out, pwm_out and period_start = 0. at_target = 1, since target equals current.
- cmd is registered on every clk (cmd_q). cmd_q is not synchronised further; the PIO shares clk.
- Prescaler counts 0..PRESCALE-1.
  - tick is asserted in the cycle where the count equals PRESCALE-1, and the count then wraps to 0.
- Phase counter is 7 bits, 0..126, and advances on tick.
  - The PWM period is 127 ticks = 127*PRESCALE clk cycles.
  - 126 wraps to 0. Phase never takes the value 127.
- period_start is a registered 1-clk pulse, asserted in the clk after a tick that wraps the phase from 126 to 0.
- Target latch: on each wrap tick, tgt_dir/tgt_mag <= cmd_q. The target is otherwise stable, so a cmd change mid-period takes effect only at the next boundary.
- Ramp counter counts wrap ticks 0..RAMP_PERIODS-1. On the wrap tick where it reaches RAMP_PERIODS-1, exactly one step is applied, evaluated against the target latched in that same cycle:
  - dir_out != tgt_dir and duty_cur > 0: duty_cur - 1.
  - dir_out != tgt_dir and duty_cur == 0: dir_out <= tgt_dir. Magnitude unchanged; that step is consumed by the reversal.
  - dir_out == tgt_dir and duty_cur < tgt_mag: duty_cur + 1.
  - dir_out == tgt_dir and duty_cur > tgt_mag: duty_cur - 1.
  - dir_out == tgt_dir and duty_cur == tgt_mag: hold.
- Step size is always 1 LSB. No saturation logic is needed: 0..127 is closed under a ±1 step toward an in-range target.
- pwm_out <= enable and (phase < duty_cur), registered one clk after the phase/duty update.
  - duty_cur = 0 gives a constant low output.
  - duty_cur = 127 gives a constant high output.
- at_target = (dir_out == tgt_dir) and (duty_cur == tgt_mag). It is combinational from registers.
- enable = 0 (synchronous effect):
  - Prescaler, phase and ramp counters are held at 0.
  - duty_cur is cleared to 0 on the next clk.
  - pwm_out = 0 on the next clk.
  - period_start stays 0.
  - dir_out holds.
  - Target latch is frozen.
- Re-enable: counting restarts from phase 0. The first wrap happens after 127*PRESCALE clks, and the ramp then starts from 0.
- Simultaneous events:
  - enable falling on a wrap tick: enable wins and no step is applied.
  - cmd changing in the clk of the wrap: the value sampled into cmd_q before that edge is latched.
- Reset asserted mid-operation: all registers clear immediately, asynchronously. pwm_out drops without waiting for the clock.

Test Plan (PRESCALE=2, RAMP_PERIODS=1; period = 254 clk):
- Reset: hold reset_n=0 with cmd=0xFF and enable=1 -> pwm_out=0, dir_out=0, duty_cur=0, period_start=0 throughout. After release, the first period_start appears 254 clk later.
- Ramp up: cmd=0x03, enable=1 -> target latched at 1st boundary, duty_cur=1. Then duty_cur=2, then 3 at successive boundaries, and at_target=1 after the 3rd step. Steady state: pwm_out high 6 clk per 254-clk period.
- Reversal: from dir=0/duty=3, set cmd=0x83 -> duty_cur steps 2,1,0, then dir_out=1 with duty 0 for one period, then 1,2,3. pwm_out is never high while dir_out toggles.
- Extremes: ramp to cmd=0x7F -> pwm_out constant high once duty_cur=127. Then cmd=0x00 -> descends 126..0, ending constant low.
- Mid-period command: change cmd 0x05->0x02 at phase 60 -> no duty change until the next boundary. The step direction follows 0x02 from that boundary.
- Disable/reset mid-run: drop enable at duty 40, phase 10 -> pwm_out=0 and duty_cur=0 on the next clk, dir_out held. A reset_n pulse mid-high-phase clears pwm_out asynchronously.
